// File: rtl/icdir_wr.sv
// ----------------------------------------------------------------------------
// icdir_wr -- I-cache directory write-side controller
//
// Turns reload fills, single-line invalidates and flush-all requests into
// directory write commands. Out of reset, and after every flush, it sweeps
// all LINES entries to invalid before taking new traffic. It also tells the
// lookup side when the entry it is reading is being overwritten this cycle.
//
// Ports
//   clk        in   1        clock, all state on posedge
//   rst_n      in   1        asynchronous reset, active low
//   fill_val   in   1        fill request valid
//   fill_rdy   out  1        fill accepted when fill_val & fill_rdy
//   fill_adr   in   ADR_W    line index to fill
//   fill_tag   in   TAG_W    tag to install
//   inv_val    in   1        single-line invalidate valid
//   inv_rdy    out  1        invalidate accepted when inv_val & inv_rdy
//   inv_adr    in   ADR_W    line index to invalidate
//   flush_val  in   1        invalidate-all request (pulse)
//   init_done  out  1        high once the first sweep after reset is done
//   lk_adr     in   ADR_W    index on the directory read port this cycle
//   lk_stall   out  1        lookup this cycle sees stale/overridden data
//   wr_en      out  4        directory write enable (4'hF or 4'h0)
//   wr_adr     out  ADR_W    directory write index
//   wr_dat     out  TAG_W+1  directory write data {valid, tag}
//
// Handshake: a request transfers on a rising clk edge where both its val and
// its rdy are high. rdy is a combinational function of state, flush_val and
// inv_val (never of the requester's own val), so a requester may hold val
// high until it sees rdy. Only one request transfers per cycle:
// flush beats invalidate beats fill.
// ----------------------------------------------------------------------------
module icdir_wr #(
    parameter int LINES       = 128,
    parameter int ADR_W       = 7,
    parameter int TAG_W       = 21,
    parameter int SHARED_PORT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_val,
    output logic             fill_rdy,
    input  logic [ADR_W-1:0] fill_adr,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inv_val,
    output logic             inv_rdy,
    input  logic [ADR_W-1:0] inv_adr,
    input  logic             flush_val,
    output logic             init_done,
    input  logic [ADR_W-1:0] lk_adr,
    output logic             lk_stall,
    output logic [3:0]       wr_en,
    output logic [ADR_W-1:0] wr_adr,
    output logic [TAG_W:0]   wr_dat
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ADR_W-1:0] LAST_IDX = ADR_W'(LINES - 1);
    // One extra bit so LINES == 2**ADR_W is representable.
    localparam logic [ADR_W:0]   LINES_V  = (ADR_W + 1)'(LINES);

    state_t           state, state_nxt;
    logic [ADR_W-1:0] cnt, cnt_nxt;
    logic             init_done_nxt;
    logic [3:0]       wr_en_nxt;
    logic [ADR_W-1:0] wr_adr_nxt;
    logic [TAG_W:0]   wr_dat_nxt;
    logic             fill_acc;
    logic             inv_acc;
    logic             fill_in_range;
    logic             inv_in_range;

    // Indices past the populated part of the directory complete the
    // handshake but are never written.
    assign fill_in_range = {1'b0, fill_adr} < LINES_V;
    assign inv_in_range  = {1'b0, inv_adr}  < LINES_V;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        init_done_nxt = init_done;
        wr_en_nxt     = 4'h0;
        wr_adr_nxt    = wr_adr;
        wr_dat_nxt    = wr_dat;
        fill_rdy      = 1'b0;
        inv_rdy       = 1'b0;
        fill_acc      = 1'b0;
        inv_acc       = 1'b0;

        case (state)
            ST_SWEEP: begin
                // flush_val is ignored here: the running sweep already
                // clears everything, so a restart would only add latency.
                wr_en_nxt  = 4'hF;
                wr_adr_nxt = cnt;
                wr_dat_nxt = '0;
                if (cnt == LAST_IDX) begin
                    cnt_nxt       = '0;
                    state_nxt     = ST_IDLE;
                    init_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + ADR_W'(1);
                end
            end
            ST_IDLE: begin
                if (flush_val) begin
                    state_nxt = ST_SWEEP;
                    cnt_nxt   = '0;
                end else begin
                    inv_rdy  = 1'b1;
                    fill_rdy = ~inv_val;
                    inv_acc  = inv_val;
                    fill_acc = fill_val & ~inv_val;
                    if (inv_acc && inv_in_range) begin
                        wr_en_nxt  = 4'hF;
                        wr_adr_nxt = inv_adr;
                        wr_dat_nxt = '0;
                    end else if (fill_acc && fill_in_range) begin
                        wr_en_nxt  = 4'hF;
                        wr_adr_nxt = fill_adr;
                        wr_dat_nxt = {1'b1, fill_tag};
                    end
                end
            end
            default: begin
                state_nxt = ST_SWEEP;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SWEEP;
            cnt       <= '0;
            init_done <= 1'b0;
            wr_en     <= 4'h0;
            wr_adr    <= '0;
            wr_dat    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_done <= init_done_nxt;
            wr_en     <= wr_en_nxt;
            wr_adr    <= wr_adr_nxt;
            wr_dat    <= wr_dat_nxt;
        end
    end

    // Until the first sweep finishes the directory content is garbage, so
    // every lookup is stalled. With a shared RAM port any write steals the
    // read, otherwise only a write to the same index matters.
    assign lk_stall = ~init_done
                    | (wr_en[0] & ((SHARED_PORT != 0) | (wr_adr == lk_adr)));

endmodule

// File: tb/tb_icdir_wr.sv
// ----------------------------------------------------------------------------
// tb_icdir_wr -- bench for icdir_wr
//
// Two instances share all inputs: "a" (LINES=128, separate ports) and
// "b" (LINES=100, shared RAM port). A behavioural model per instance tracks
// sweep position, init status and the expected write command; every cycle
// all outputs of both instances are compared against it. Instance "a" also
// feeds a write scoreboard queue.
// ----------------------------------------------------------------------------
module tb_icdir_wr;

    localparam int ADR_W = 7;
    localparam int TAG_W = 21;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fill_val;
    logic [ADR_W-1:0] fill_adr;
    logic [TAG_W-1:0] fill_tag;
    logic             inv_val;
    logic [ADR_W-1:0] inv_adr;
    logic             flush_val;
    logic [ADR_W-1:0] lk_adr;

    logic             a_fill_rdy, a_inv_rdy, a_init_done, a_lk_stall;
    logic [3:0]       a_wr_en;
    logic [ADR_W-1:0] a_wr_adr;
    logic [TAG_W:0]   a_wr_dat;
    logic             b_fill_rdy, b_inv_rdy, b_init_done, b_lk_stall;
    logic [3:0]       b_wr_en;
    logic [ADR_W-1:0] b_wr_adr;
    logic [TAG_W:0]   b_wr_dat;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    icdir_wr #(.LINES(128), .ADR_W(ADR_W), .TAG_W(TAG_W), .SHARED_PORT(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .fill_val(fill_val), .fill_rdy(a_fill_rdy), .fill_adr(fill_adr), .fill_tag(fill_tag),
        .inv_val(inv_val), .inv_rdy(a_inv_rdy), .inv_adr(inv_adr),
        .flush_val(flush_val), .init_done(a_init_done),
        .lk_adr(lk_adr), .lk_stall(a_lk_stall),
        .wr_en(a_wr_en), .wr_adr(a_wr_adr), .wr_dat(a_wr_dat)
    );

    icdir_wr #(.LINES(100), .ADR_W(ADR_W), .TAG_W(TAG_W), .SHARED_PORT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .fill_val(fill_val), .fill_rdy(b_fill_rdy), .fill_adr(fill_adr), .fill_tag(fill_tag),
        .inv_val(inv_val), .inv_rdy(b_inv_rdy), .inv_adr(inv_adr),
        .flush_val(flush_val), .init_done(b_init_done),
        .lk_adr(lk_adr), .lk_stall(b_lk_stall),
        .wr_en(b_wr_en), .wr_adr(b_wr_adr), .wr_dat(b_wr_dat)
    );

    // ---------------- reference model ----------------
    int         lines_of [2] = '{128, 100};
    bit         shared_of[2] = '{1'b0, 1'b1};
    int         m_pos [2];      // next sweep index, -1 when not sweeping
    bit         m_done[2];
    logic [3:0] m_en  [2];
    int         m_adr [2];
    logic [TAG_W:0] m_dat [2];

    // scoreboard for instance a: {adr, dat} of every expected write
    logic [ADR_W+TAG_W:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]  = 0;
            m_done[i] = 1'b0;
            m_en[i]   = 4'h0;
            m_adr[i]  = 0;
            m_dat[i]  = '0;
        end
        exp_q.delete();
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_pos[i] >= 0) begin
                m_en[i]  = 4'hF;
                m_adr[i] = m_pos[i];
                m_dat[i] = '0;
                m_pos[i]++;
                if (m_pos[i] == lines_of[i]) begin
                    m_pos[i]  = -1;
                    m_done[i] = 1'b1;
                end
            end else if (flush_val) begin
                m_en[i]  = 4'h0;
                m_pos[i] = 0;
            end else if (inv_val) begin
                if (int'(inv_adr) < lines_of[i]) begin
                    m_en[i]  = 4'hF;
                    m_adr[i] = int'(inv_adr);
                    m_dat[i] = '0;
                end else begin
                    m_en[i] = 4'h0;
                end
            end else if (fill_val) begin
                if (int'(fill_adr) < lines_of[i]) begin
                    m_en[i]  = 4'hF;
                    m_adr[i] = int'(fill_adr);
                    m_dat[i] = {1'b1, fill_tag};
                end else begin
                    m_en[i] = 4'h0;
                end
            end else begin
                m_en[i] = 4'h0;
            end
            if (i == 0 && m_en[0] == 4'hF)
                exp_q.push_back({ADR_W'(m_adr[0]), m_dat[0]});
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic [3:0] en, input logic [ADR_W-1:0] adr,
                              input logic [TAG_W:0] dat, input logic frdy, input logic irdy,
                              input logic idone, input logic stall);
        string pfx;
        bit    e_irdy, e_frdy, e_stall;
        pfx     = (i == 0) ? "a" : "b";
        e_irdy  = (m_pos[i] < 0) && !flush_val;
        e_frdy  = e_irdy && !inv_val;
        e_stall = !m_done[i] || (m_en[i][0] && (shared_of[i] || m_adr[i] == int'(lk_adr)));
        check({pfx, ".wr_en"},     32'(en),    32'(m_en[i]));
        check({pfx, ".wr_adr"},    32'(adr),   32'(m_adr[i]));
        check({pfx, ".wr_dat"},    32'(dat),   32'(m_dat[i]));
        check({pfx, ".fill_rdy"},  32'(frdy),  32'(e_frdy));
        check({pfx, ".inv_rdy"},   32'(irdy),  32'(e_irdy));
        check({pfx, ".init_done"}, 32'(idone), 32'(m_done[i]));
        check({pfx, ".lk_stall"},  32'(stall), 32'(e_stall));
    endtask

    task automatic check_all();
        check_inst(0, a_wr_en, a_wr_adr, a_wr_dat, a_fill_rdy, a_inv_rdy, a_init_done, a_lk_stall);
        check_inst(1, b_wr_en, b_wr_adr, b_wr_dat, b_fill_rdy, b_inv_rdy, b_init_done, b_lk_stall);
        if (a_wr_en == 4'hF) begin
            if (exp_q.size() == 0)
                check("a.sb_extra_write", 32'(a_wr_adr), 32'hFFFF_FFFF);
            else
                check("a.sb_write", 32'({a_wr_adr, a_wr_dat}), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge: drive, check at the falling edge,
    // step the model at the next rising edge.
    task automatic cyc(input bit fv, input int fa, input logic [TAG_W-1:0] ft,
                       input bit iv, input int ia, input bit fl, input int la);
        fill_val  = fv;
        fill_adr  = ADR_W'(fa);
        fill_tag  = ft;
        inv_val   = iv;
        inv_adr   = ADR_W'(ia);
        flush_val = fl;
        lk_adr    = ADR_W'(la);
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input bit fv);
        cyc(fv, $urandom_range(0, 127), TAG_W'($urandom), 1'b0, 0, 1'b0, $urandom_range(0, 127));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        fill_val  = 1'b0;
        fill_adr  = '0;
        fill_tag  = '0;
        inv_val   = 1'b0;
        inv_adr   = '0;
        flush_val = 1'b0;
        lk_adr    = '0;
        model_reset();

        // reset state
        #2;
        check_all();

        // initial sweep: 128 writes 0..127 on a, 100 on b
        release_reset();
        check("a.sweep_first_adr", 32'(a_wr_adr), 32'd0);
        for (int k = 0; k < 127; k++) idle(1'b0);
        check("a.sweep_last_adr", 32'(a_wr_adr), 32'd127);
        check("a.init_done_at_127", 32'(a_init_done), 32'd1);
        check("a.fill_rdy_at_127", 32'(a_fill_rdy), 32'd1);

        // single fill
        cyc(1'b1, 5, 21'h1ABCD, 1'b0, 0, 1'b0, 0);
        check("fill_wr_en", 32'(a_wr_en), 32'hF);
        check("fill_wr_adr", 32'(a_wr_adr), 32'd5);
        check("fill_wr_dat", 32'(a_wr_dat), 32'h21ABCD);
        idle(1'b0);
        check("fill_wr_en_off", 32'(a_wr_en), 32'h0);

        // fill vs invalidate in the same cycle
        cyc(1'b1, 3, 21'h0F00D, 1'b1, 9, 1'b0, 3);
        check("inv_wins_adr", 32'(a_wr_adr), 32'd9);
        check("inv_wins_dat", 32'(a_wr_dat), 32'd0);
        cyc(1'b1, 3, 21'h0F00D, 1'b0, 0, 1'b0, 9);
        check("held_fill_adr", 32'(a_wr_adr), 32'd3);
        check("held_fill_dat", 32'(a_wr_dat), 32'h20F00D);

        // lookup collision
        cyc(1'b1, 7, 21'h12345, 1'b0, 0, 1'b0, 0);
        lk_adr = 7'd7;
        #1;
        check("a.stall_same", 32'(a_lk_stall), 32'd1);
        check("b.stall_same", 32'(b_lk_stall), 32'd1);
        lk_adr = 7'd8;
        #1;
        check("a.stall_other", 32'(a_lk_stall), 32'd0);
        check("b.stall_other", 32'(b_lk_stall), 32'd1);

        // flush, then a second flush 10 cycles in; fills pending throughout
        cyc(1'b1, 11, 21'h0AAAA, 1'b0, 0, 1'b1, 0);
        check("flush_no_write", 32'(a_wr_en), 32'h0);
        for (int k = 0; k < 10; k++) idle(1'b1);
        cyc(1'b1, 12, 21'h0BBBB, 1'b0, 0, 1'b1, 0);
        for (int k = 0; k < 125; k++) idle(1'b1);

        // reset in the middle of a sweep
        cyc(1'b0, 0, '0, 1'b0, 0, 1'b1, 0);
        for (int k = 0; k < 200 && !(m_pos[0] >= 0 && m_en[0] == 4'hF && m_adr[0] == 60); k++)
            idle(1'b0);
        check("a.reached_adr_60", 32'(a_wr_adr), 32'd60);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_clears_wr_en", 32'(a_wr_en), 32'h0);
        @(negedge clk);
        release_reset();
        check("a.restart_adr", 32'(a_wr_adr), 32'd0);
        check("b.restart_adr", 32'(b_wr_adr), 32'd0);
        for (int k = 0; k < 130; k++) idle(1'b0);

        // index beyond LINES on b
        cyc(1'b1, 127, 21'h1FFFF, 1'b0, 0, 1'b0, 127);
        check("b.oob_no_write", 32'(b_wr_en), 32'h0);
        check("a.top_write", 32'(a_wr_adr), 32'd127);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            cyc(bit'($urandom_range(0, 1)), $urandom_range(0, 127), TAG_W'($urandom),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 127),
                ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 1) == 1) ? m_adr[0] : $urandom_range(0, 127));
        end

        // drain
        fill_val  = 1'b0;
        inv_val   = 1'b0;
        flush_val = 1'b0;
        @(negedge clk);
        check_all();
        check("a.sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
